// File: rtl/pam4_symbol_source.sv
// 4-PAM stimulus source for the pulse-shaping filter.
// Emits PRBS15, impulse, DC or fixed-pattern symbols, zero-stuffed to OSR.
module pam4_symbol_source #(
    parameter int                 OSR        = 4,
    parameter logic [14:0]        SEED       = 15'h0001,
    parameter logic signed [17:0] LVL_HI     = 18'sd98304,
    parameter logic signed [17:0] LVL_LO     = 18'sd32768,
    parameter logic signed [17:0] IMPULSE    = 18'sd131071,
    parameter bit                 ZERO_STUFF = 1'b1
) (
    input  logic                   sys_clk,
    input  logic                   reset,
    input  logic                   sam_clk_en,
    input  logic [1:0]             mode,
    output logic [17:0]            x_out,
    output logic                   sym_clk_en,
    output logic [1:0]             sym_out,
    output logic [$clog2(OSR)-1:0] phase
);

    localparam int PW = $clog2(OSR);
    localparam logic [14:0] SEED_EFF = (SEED == 15'd0) ? 15'h0001 : SEED;
    localparam logic [PW-1:0] PH_LAST = PW'(OSR - 1);

    localparam logic [1:0] M_PRBS = 2'd0;
    localparam logic [1:0] M_IMP  = 2'd1;
    localparam logic [1:0] M_DC   = 2'd2;
    localparam logic [1:0] M_PAT  = 2'd3;

    logic [PW-1:0] ph;
    logic [14:0]   lfsr;
    logic [1:0]    pat_cnt;
    logic          armed;
    logic [1:0]    prev_mode;
    logic          prev_vld;

    logic          fb1;
    logic          fb2;
    logic [14:0]   lfsr1;
    logic [14:0]   lfsr2;
    logic          new_entry;
    logic [1:0]    pat_base;
    logic          arm_eff;
    logic [1:0]    nxt_sym;
    logic [17:0]   nxt_lvl;
    logic          boundary;

    function automatic logic [17:0] gray_lvl(input logic [1:0] s);
        logic [17:0] l;
        unique case (s)
            2'b00: l = -LVL_HI;
            2'b01: l = -LVL_LO;
            2'b11: l = LVL_LO;
            default: l = LVL_HI;
        endcase
        return l;
    endfunction

    assign boundary = sam_clk_en && (ph == '0);

    always_comb begin
        fb1       = lfsr[14] ^ lfsr[13];
        lfsr1     = {lfsr[13:0], fb1};
        fb2       = lfsr1[14] ^ lfsr1[13];
        lfsr2     = {lfsr1[13:0], fb2};
        // A mode counts as newly entered after reset or any mode change.
        new_entry = !prev_vld || (prev_mode != mode);
        pat_base  = new_entry ? 2'd0 : pat_cnt;
        arm_eff   = new_entry || armed;
        nxt_sym   = 2'b00;
        nxt_lvl   = '0;
        unique case (mode)
            M_PRBS: begin
                nxt_sym = {fb1, fb2};
                nxt_lvl = gray_lvl({fb1, fb2});
            end
            M_IMP: begin
                if (arm_eff) begin
                    nxt_sym = 2'b10;
                    nxt_lvl = IMPULSE;
                end
            end
            M_DC: begin
                nxt_sym = 2'b10;
                nxt_lvl = LVL_HI;
            end
            default: begin
                nxt_sym = pat_base ^ (pat_base >> 1);
                nxt_lvl = gray_lvl(pat_base ^ (pat_base >> 1));
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            ph         <= '0;
            lfsr       <= SEED_EFF;
            pat_cnt    <= 2'd0;
            armed      <= 1'b1;
            prev_mode  <= 2'd0;
            prev_vld   <= 1'b0;
            x_out      <= '0;
            sym_out    <= 2'b00;
            sym_clk_en <= 1'b0;
        end else begin
            sym_clk_en <= 1'b0;
            if (sam_clk_en) begin
                ph <= (ph == PH_LAST) ? '0 : ph + 1'b1;
                if (boundary) begin
                    sym_clk_en <= 1'b1;
                    x_out      <= nxt_lvl;
                    sym_out    <= nxt_sym;
                    prev_mode  <= mode;
                    prev_vld   <= 1'b1;
                    if (mode == M_PRBS) lfsr <= lfsr2;
                    if (mode == M_PAT) pat_cnt <= pat_base + 2'd1;
                    if (mode == M_IMP) armed <= 1'b0;
                end else if (ZERO_STUFF) begin
                    x_out <= '0;
                end
            end
        end
    end

    assign phase = ph;

endmodule

// File: tb/tb_pam4_symbol_source.sv
// Scoreboard bench for pam4_symbol_source (zero-stuff and hold variants).
module tb_pam4_symbol_source;

    logic        sys_clk = 1'b0;
    logic        reset = 1'b1;
    logic        sam_clk_en = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [17:0] x_out, x_hold;
    logic        sym_clk_en, sym_en_hold;
    logic [1:0]  sym_out, sym_hold;
    logic [1:0]  phase, phase_hold;

    pam4_symbol_source #(.OSR(4), .ZERO_STUFF(1'b1)) dut (
        .sys_clk(sys_clk), .reset(reset), .sam_clk_en(sam_clk_en),
        .mode(mode), .x_out(x_out), .sym_clk_en(sym_clk_en),
        .sym_out(sym_out), .phase(phase)
    );

    pam4_symbol_source #(.OSR(4), .ZERO_STUFF(1'b0)) dut_hold (
        .sys_clk(sys_clk), .reset(reset), .sam_clk_en(sam_clk_en),
        .mode(mode), .x_out(x_hold), .sym_clk_en(sym_en_hold),
        .sym_out(sym_hold), .phase(phase_hold)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        int x;
        int h;
        int s;
        int p;
        int e;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          failures = 0;
    logic [14:0] m_lfsr = 15'h0001;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    function automatic int lvl(input int s);
        case (s)
            0: return -98304;
            1: return -32768;
            3: return 32768;
            2: return 98304;
            default: return 0;
        endcase
    endfunction

    // Software PRBS15 (x^15+x^14+1), two bits per symbol, first bit is MSB.
    function automatic int prbs_sym();
        logic b1, b2;
        b1 = m_lfsr[14] ^ m_lfsr[13];
        m_lfsr = {m_lfsr[13:0], b1};
        b2 = m_lfsr[14] ^ m_lfsr[13];
        m_lfsr = {m_lfsr[13:0], b2};
        return {30'd0, b1, b2};
    endfunction

    always @(posedge sys_clk) begin
        exp_t e;
        if (!reset && sam_clk_en) begin
            #1;
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL scoreboard_empty actual=0 expected=1");
            end else begin
                e = q.pop_front();
                chk("x_out", $signed(x_out), e.x);
                chk("x_hold", $signed(x_hold), e.h);
                chk("sym_out", int'(sym_out), e.s);
                chk("phase", int'(phase), e.p);
                chk("sym_clk_en", int'(sym_clk_en), e.e);
                chk("sym_hold", int'(sym_hold), e.s);
            end
        end else if (!reset) begin
            #1;
            chk("sym_clk_en_idle", int'(sym_clk_en), 0);
        end
    end

    task automatic samp(input int md, input int es, input int ex,
                        input int eh, input int ep, input int ee);
        exp_t e;
        @(negedge sys_clk);
        mode = md[1:0];
        sam_clk_en = 1'b1;
        e = '{ex, eh, es, ep, ee};
        q.push_back(e);
        @(negedge sys_clk);
        sam_clk_en = 1'b0;
        repeat (2) @(negedge sys_clk);
    endtask

    task automatic sym(input int mb, input int mr, input int es, input int ex);
        samp(mb, es, ex, ex, 1, 1);
        samp(mr, es, 0, ex, 2, 0);
        samp(mr, es, 0, ex, 3, 0);
        samp(mr, es, 0, ex, 0, 0);
    endtask

    task automatic prbs_syms(input int n);
        int s;
        for (int i = 0; i < n; i++) begin
            s = prbs_sym();
            sym(0, 0, s, lvl(s));
        end
    endtask

    task automatic do_reset(input int md);
        @(negedge sys_clk);
        reset = 1'b1;
        sam_clk_en = 1'b1;
        mode = md[1:0];
        @(posedge sys_clk);
        #1;
        chk("rst_x_out", $signed(x_out), 0);
        chk("rst_x_hold", $signed(x_hold), 0);
        chk("rst_sym_out", int'(sym_out), 0);
        chk("rst_phase", int'(phase), 0);
        chk("rst_sym_clk_en", int'(sym_clk_en), 0);
        @(negedge sys_clk);
        reset = 1'b0;
        sam_clk_en = 1'b0;
        m_lfsr = 15'h0001;
        @(negedge sys_clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int s;
        do_reset(0);
        prbs_syms(8);

        // Fixed pattern, run past one wrap so the counter is left non-zero.
        sym(3, 3, 0, -98304);
        sym(3, 3, 1, -32768);
        sym(3, 3, 3, 32768);
        sym(3, 3, 2, 98304);
        sym(3, 3, 0, -98304);

        // Back to PRBS, then switch to pattern mode mid-symbol at ph = 2.
        s = prbs_sym();
        samp(0, s, lvl(s), lvl(s), 1, 1);
        samp(0, s, 0, lvl(s), 2, 0);
        samp(3, s, 0, lvl(s), 3, 0);
        samp(3, s, 0, lvl(s), 0, 0);
        sym(3, 3, 0, -98304);
        sym(3, 3, 1, -32768);

        // Impulse on entry, silence after, re-arm via DC.
        sym(1, 1, 2, 131071);
        sym(1, 1, 0, 0);
        sym(1, 1, 0, 0);
        sym(2, 1, 2, 98304);
        sym(1, 1, 2, 131071);
        sym(1, 1, 0, 0);

        do_reset(1);
        sym(1, 1, 2, 131071);
        sym(1, 1, 0, 0);
        sym(1, 1, 0, 0);
        sym(1, 1, 0, 0);

        sym(2, 2, 2, 98304);
        sym(2, 2, 2, 98304);
        sym(2, 2, 2, 98304);

        // Reset mid-symbol in PRBS mode, then replay the opening sequence.
        do_reset(0);
        prbs_syms(2);
        s = prbs_sym();
        samp(0, s, lvl(s), lvl(s), 1, 1);
        samp(0, s, 0, lvl(s), 2, 0);
        do_reset(0);
        prbs_syms(8);

        repeat (4) @(negedge sys_clk);
        chk("queue_drain", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
